// File: rtl/cache_line_param.sv
// One cache line of 2^LINEBITS words with dcache rd/wr and icache rd ports plus a flush/fill engine.
// Build option CACHE_LINE_PARAM_DIRTY_WORDMASK_EN: per-word dirty bits so flush writes back only dirty words.
module cache_line_param #(
  parameter int ADDRBITS    = 32,
  parameter int DATABITS    = 32,
  parameter int LINEBITS    = 5,
  parameter int MAXMISSBITS = 8,
  parameter int WORDLENBITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDRBITS-1:0]    dcache_line_rdaddr,
  input  logic                   dcache_line_rdreq,
  output logic [DATABITS-1:0]    dcache_line_out,
  output logic                   dcache_line_out_valid,
  input  logic [ADDRBITS-1:0]    dcache_line_wraddr,
  input  logic [DATABITS-1:0]    dcache_line_in,
  input  logic [WORDLENBITS-1:0] dcache_line_in_wordlen,
  input  logic                   dcache_line_wrreq,
  input  logic [ADDRBITS-1:0]    icache_line_rdaddr,
  input  logic                   icache_line_rdreq,
  output logic [DATABITS-1:0]    icache_line_out,
  output logic                   icache_line_out_valid,
  output logic                   cache_line_dirty,
  output logic                   cache_line_miss,
  input  logic                   cache_line_flush,
  input  logic                   cache_line_fill,
  input  logic                   cache_line_pause,
  output logic [MAXMISSBITS-1:0] cache_line_misscnt,
  input  logic [ADDRBITS-1:0]    cache_new_region,
  output logic                   cache_line_ready,
  output logic [ADDRBITS-1:0]    mem_addr,
  output logic [DATABITS-1:0]    mem_in,
  input  logic [DATABITS-1:0]    mem_out,
  input  logic                   mem_out_valid,
  output logic                   mem_wrreq,
  output logic                   mem_rdreq
);

  localparam int NBYTES  = DATABITS / 8;
  localparam int BSEL    = $clog2(NBYTES);
  localparam int NWORDS  = 1 << LINEBITS;
  localparam int TAGBITS = ADDRBITS - LINEBITS - BSEL;
  localparam logic [LINEBITS-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_FILL_REQ,
    S_FILL_WAIT
  } state_t;

  state_t              state;
  logic [LINEBITS-1:0] idx;
  logic [TAGBITS-1:0]  tag;
  logic [TAGBITS-1:0]  new_tag;
  logic                line_valid;
  logic                fill_pending;
  logic [DATABITS-1:0] line_data [NWORDS];

`ifdef CACHE_LINE_PARAM_DIRTY_WORDMASK_EN
  logic [NWORDS-1:0]   dirty_mask;
  wire                 word_dirty = dirty_mask[idx];
  assign cache_line_dirty = |dirty_mask;
`else
  logic                dirty_bit;
  wire                 word_dirty = 1'b1;
  assign cache_line_dirty = dirty_bit;
`endif

  // Address decode for the three request ports and the fill region.
  wire [TAGBITS-1:0]  d_rd_tag   = dcache_line_rdaddr[ADDRBITS-1:LINEBITS+BSEL];
  wire [LINEBITS-1:0] d_rd_idx   = dcache_line_rdaddr[LINEBITS+BSEL-1:BSEL];
  wire [TAGBITS-1:0]  i_rd_tag   = icache_line_rdaddr[ADDRBITS-1:LINEBITS+BSEL];
  wire [LINEBITS-1:0] i_rd_idx   = icache_line_rdaddr[LINEBITS+BSEL-1:BSEL];
  wire [TAGBITS-1:0]  wr_tag     = dcache_line_wraddr[ADDRBITS-1:LINEBITS+BSEL];
  wire [LINEBITS-1:0] wr_idx     = dcache_line_wraddr[LINEBITS+BSEL-1:BSEL];
  wire [BSEL-1:0]     wr_off     = dcache_line_wraddr[BSEL-1:0];
  wire [TAGBITS-1:0]  region_tag = cache_new_region[ADDRBITS-1:LINEBITS+BSEL];

  wire unused_addr_bits = &{1'b0, dcache_line_rdaddr[BSEL-1:0], icache_line_rdaddr[BSEL-1:0],
                            cache_new_region[LINEBITS+BSEL-1:0]};

  wire lookup_ok = line_valid && (state == S_IDLE);
  wire d_rd_hit  = dcache_line_rdreq && lookup_ok && (d_rd_tag == tag);
  wire i_rd_hit  = icache_line_rdreq && lookup_ok && (i_rd_tag == tag);

  logic [7:0]          size_mask;
  logic [2:0]          align_mask;
  logic                size_ok;
  logic                wr_aligned;
  logic [NBYTES-1:0]   wr_be;
  logic [DATABITS-1:0] wr_shifted;

  // NOTE: every signal written in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    size_mask  = 8'h00;
    align_mask = 3'd0;
    size_ok    = 1'b0;
    case (dcache_line_in_wordlen)
      WORDLENBITS'(0): begin size_mask = 8'h01; align_mask = 3'd0; size_ok = 1'b1; end
      WORDLENBITS'(1): begin size_mask = 8'h03; align_mask = 3'd1; size_ok = 1'b1; end
      WORDLENBITS'(2): begin size_mask = 8'h0f; align_mask = 3'd3; size_ok = 1'b1; end
      WORDLENBITS'(3): begin size_mask = 8'hff; align_mask = 3'd7; size_ok = (DATABITS == 64); end
      default: ;
    endcase
    wr_aligned = size_ok && ((wr_off & align_mask[BSEL-1:0]) == '0);
    wr_be      = size_mask[NBYTES-1:0] << wr_off;
    wr_shifted = dcache_line_in << {wr_off, 3'b000};
  end

  wire wr_hit  = dcache_line_wrreq && lookup_ok && (wr_tag == tag) && wr_aligned;
  wire any_req = dcache_line_rdreq || icache_line_rdreq || dcache_line_wrreq;
  wire any_hit = d_rd_hit || i_rd_hit || wr_hit;

  wire fill_store = (state == S_FILL_WAIT) && mem_out_valid;
  wire flush_step = (state == S_FLUSH) && (!word_dirty || !cache_line_pause);

  assign cache_line_ready = (state == S_IDLE);

  // NOTE: the line storage has no reset; line_valid alone says whether its contents mean anything.
  always_ff @(posedge clk) begin
    if (fill_store) begin
      line_data[idx] <= mem_out;
    end else if (wr_hit) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) line_data[wr_idx][8*b +: 8] <= wr_shifted[8*b +: 8];
      end
    end
  end

  // Read ports sample the array before this edge's write lands, so a same-word write returns old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      dcache_line_out       <= '0;
      dcache_line_out_valid <= 1'b0;
      icache_line_out       <= '0;
      icache_line_out_valid <= 1'b0;
    end else begin
      dcache_line_out_valid <= d_rd_hit;
      icache_line_out_valid <= i_rd_hit;
      if (d_rd_hit) dcache_line_out <= line_data[d_rd_idx];
      if (i_rd_hit) icache_line_out <= line_data[i_rd_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      idx                <= '0;
      tag                <= '0;
      new_tag            <= '0;
      line_valid         <= 1'b0;
      fill_pending       <= 1'b0;
      cache_line_miss    <= 1'b0;
      cache_line_misscnt <= '0;
      mem_addr           <= '0;
      mem_in             <= '0;
      mem_wrreq          <= 1'b0;
      mem_rdreq          <= 1'b0;
`ifdef CACHE_LINE_PARAM_DIRTY_WORDMASK_EN
      dirty_mask         <= '0;
`else
      dirty_bit          <= 1'b0;
`endif
    end else begin
      mem_wrreq       <= 1'b0;
      mem_rdreq       <= 1'b0;
      cache_line_miss <= any_req && !any_hit;

      // Misses seen while the engine is busy are flagged but not counted.
      if (any_req && !any_hit && (state == S_IDLE) && (cache_line_misscnt != '1))
        cache_line_misscnt <= cache_line_misscnt + 1'b1;

      if (wr_hit) begin
`ifdef CACHE_LINE_PARAM_DIRTY_WORDMASK_EN
        dirty_mask[wr_idx] <= 1'b1;
`else
        dirty_bit <= 1'b1;
`endif
      end

      case (state)
        S_IDLE: begin
          idx <= '0;
          if (cache_line_flush && cache_line_dirty) begin
            state        <= S_FLUSH;
            fill_pending <= cache_line_fill;
            new_tag      <= region_tag;
          end else if (cache_line_fill) begin
            state      <= S_FILL_REQ;
            line_valid <= 1'b0;
            new_tag    <= region_tag;
          end
        end

        S_FLUSH: begin
          if (flush_step) begin
            if (word_dirty) begin
              mem_wrreq <= 1'b1;
              mem_addr  <= {tag, idx, {BSEL{1'b0}}};
              mem_in    <= line_data[idx];
`ifdef CACHE_LINE_PARAM_DIRTY_WORDMASK_EN
              dirty_mask[idx] <= 1'b0;
`endif
            end
            if (idx == LAST_IDX) begin
              idx <= '0;
`ifndef CACHE_LINE_PARAM_DIRTY_WORDMASK_EN
              dirty_bit <= 1'b0;
`endif
              if (fill_pending) begin
                state      <= S_FILL_REQ;
                line_valid <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        S_FILL_REQ: begin
          if (!cache_line_pause) begin
            mem_rdreq <= 1'b1;
            mem_addr  <= {new_tag, idx, {BSEL{1'b0}}};
            state     <= S_FILL_WAIT;
          end
        end

        S_FILL_WAIT: begin
          if (mem_out_valid) begin
            if (idx == LAST_IDX) begin
              state              <= S_IDLE;
              idx                <= '0;
              line_valid         <= 1'b1;
              tag                <= new_tag;
              fill_pending       <= 1'b0;
              cache_line_misscnt <= '0;
`ifdef CACHE_LINE_PARAM_DIRTY_WORDMASK_EN
              dirty_mask         <= '0;
`else
              dirty_bit          <= 1'b0;
`endif
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FILL_REQ;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_param.sv
// Directed bench for cache_line_param: fill, reads, byte merges, flush+fill, miss saturation, pause and reset.
module tb_cache_line_param;

  logic        clk;
  logic        reset;
  logic [31:0] dcache_line_rdaddr;
  logic        dcache_line_rdreq;
  logic [31:0] dcache_line_out;
  logic        dcache_line_out_valid;
  logic [31:0] dcache_line_wraddr;
  logic [31:0] dcache_line_in;
  logic [1:0]  dcache_line_in_wordlen;
  logic        dcache_line_wrreq;
  logic [31:0] icache_line_rdaddr;
  logic        icache_line_rdreq;
  logic [31:0] icache_line_out;
  logic        icache_line_out_valid;
  logic        cache_line_dirty;
  logic        cache_line_miss;
  logic        cache_line_flush;
  logic        cache_line_fill;
  logic        cache_line_pause;
  logic [7:0]  cache_line_misscnt;
  logic [31:0] cache_new_region;
  logic        cache_line_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic [31:0] mem_out;
  logic        mem_out_valid;
  logic        mem_wrreq;
  logic        mem_rdreq;

`ifdef CACHE_LINE_PARAM_DIRTY_WORDMASK_EN
  localparam int EXP_WRS = 2;
  localparam int W1 = 0;
  localparam int W3 = 1;
`else
  localparam int EXP_WRS = 32;
  localparam int W1 = 1;
  localparam int W3 = 3;
`endif

  int total = 0;
  int bad   = 0;

  // Memory model and strobe monitor state.
  int          rd_count = 0;
  int          rd_addr_err = 0;
  int          wr_after_rd = 0;
  int          overlap = 0;
  int          watched_strobes = 0;
  bit          watch_strobes = 0;
  logic [31:0] rd_base = 32'h0;
  logic [31:0] first_rd = 32'h0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] wr_q[$];
  logic [31:0] wr_data_q[$];
  bit          pending = 0;
  int          resp_wait = 0;
  logic [31:0] pend_addr = 32'h0;
  int          nomiss = 0;

  cache_line_param dut (
    .clk                    (clk),
    .reset                  (reset),
    .dcache_line_rdaddr     (dcache_line_rdaddr),
    .dcache_line_rdreq      (dcache_line_rdreq),
    .dcache_line_out        (dcache_line_out),
    .dcache_line_out_valid  (dcache_line_out_valid),
    .dcache_line_wraddr     (dcache_line_wraddr),
    .dcache_line_in         (dcache_line_in),
    .dcache_line_in_wordlen (dcache_line_in_wordlen),
    .dcache_line_wrreq      (dcache_line_wrreq),
    .icache_line_rdaddr     (icache_line_rdaddr),
    .icache_line_rdreq      (icache_line_rdreq),
    .icache_line_out        (icache_line_out),
    .icache_line_out_valid  (icache_line_out_valid),
    .cache_line_dirty       (cache_line_dirty),
    .cache_line_miss        (cache_line_miss),
    .cache_line_flush       (cache_line_flush),
    .cache_line_fill        (cache_line_fill),
    .cache_line_pause       (cache_line_pause),
    .cache_line_misscnt     (cache_line_misscnt),
    .cache_new_region       (cache_new_region),
    .cache_line_ready       (cache_line_ready),
    .mem_addr               (mem_addr),
    .mem_in                 (mem_in),
    .mem_out                (mem_out),
    .mem_out_valid          (mem_out_valid),
    .mem_wrreq              (mem_wrreq),
    .mem_rdreq              (mem_rdreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0fff_0000 | {18'b0, a[15:2]};
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_monitor(input logic [31:0] base);
    rd_base = base;
    rd_count = 0;
    rd_addr_err = 0;
    wr_after_rd = 0;
    wr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse(input logic do_fill, input logic do_flush, input logic [31:0] region);
    cache_new_region = region;
    cache_line_fill  = do_fill;
    cache_line_flush = do_flush;
    tick();
    cache_line_fill  = 1'b0;
    cache_line_flush = 1'b0;
    cache_new_region = 32'hdead_0000;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (cache_line_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("ready_in_time", cache_line_ready, 1'b1);
  endtask

  task automatic dread(input logic [31:0] a);
    dcache_line_rdaddr = a;
    dcache_line_rdreq  = 1'b1;
    tick();
    dcache_line_rdreq  = 1'b0;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [1:0] len);
    dcache_line_wraddr     = a;
    dcache_line_in         = d;
    dcache_line_in_wordlen = len;
    dcache_line_wrreq      = 1'b1;
    tick();
    dcache_line_wrreq      = 1'b0;
  endtask

  // Memory responder and strobe monitor, sampled on the falling edge.
  initial begin
    mem_out = 32'h0;
    mem_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 0;
        mem_out_valid = 1'b0;
      end else begin
        mem_out_valid = 1'b0;
        if (pending) begin
          if (resp_wait == 0) begin
            mem_out = mem_word(pend_addr);
            mem_out_valid = 1'b1;
            pending = 0;
          end else begin
            resp_wait--;
          end
        end
        if (mem_rdreq) begin
          if (mem_addr !== rd_base + 32'(rd_count * 4)) rd_addr_err++;
          if (rd_count == 0) first_rd = mem_addr;
          last_rd = mem_addr;
          rd_count++;
          pend_addr = mem_addr;
          pending = 1;
          resp_wait = 1;
        end
        if (mem_wrreq) begin
          wr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_in);
          if (rd_count != 0) wr_after_rd++;
        end
        if (mem_wrreq && mem_rdreq) overlap++;
        if (watch_strobes && (mem_wrreq || mem_rdreq)) watched_strobes++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    dcache_line_rdaddr = 32'h0;
    dcache_line_rdreq = 1'b0;
    dcache_line_wraddr = 32'h0;
    dcache_line_in = 32'h0;
    dcache_line_in_wordlen = 2'd0;
    dcache_line_wrreq = 1'b0;
    icache_line_rdaddr = 32'h0;
    icache_line_rdreq = 1'b0;
    cache_line_flush = 1'b0;
    cache_line_fill = 1'b0;
    cache_line_pause = 1'b0;
    cache_new_region = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_ready", cache_line_ready, 1'b1);
    check("rst_miss", cache_line_miss, 1'b0);
    check("rst_misscnt", cache_line_misscnt, 8'd0);
    check("rst_dirty", cache_line_dirty, 1'b0);
    check("rst_strobes", {mem_wrreq, mem_rdreq}, 2'b00);
    check("rst_valids", {dcache_line_out_valid, icache_line_out_valid}, 2'b00);
    check("rst_dout", dcache_line_out, 32'h0);

    // Plain fill.
    clear_monitor(32'h8000_0000);
    pulse(1'b1, 1'b0, 32'h8000_0000);
    check("fill_ready_low", cache_line_ready, 1'b0);
    wait_ready(1000);
    check("fill_rd_count", rd_count, 32);
    check("fill_rd_addr_seq", rd_addr_err, 0);
    check("fill_first_rd", first_rd, 32'h8000_0000);
    check("fill_last_rd", last_rd, 32'h8000_007c);
    check("fill_misscnt", cache_line_misscnt, 8'd0);
    check("fill_no_wr", wr_q.size(), 0);

    dread(32'h8000_0008);
    check("rd8_valid", dcache_line_out_valid, 1'b1);
    check("rd8_data", dcache_line_out, 32'h0fff_0002);
    check("rd8_miss", cache_line_miss, 1'b0);

    // Word write then byte merge.
    dwrite(32'h8000_0004, 32'hdead_beef, 2'd2);
    dwrite(32'h8000_0005, 32'h0000_0011, 2'd0);
    dread(32'h8000_0004);
    check("merge_data", dcache_line_out, 32'hdead_11ef);
    check("merge_dirty", cache_line_dirty, 1'b1);

    // Misaligned half and oversize dword are dropped as misses.
    dwrite(32'h8000_0001, 32'h0000_ffff, 2'd1);
    check("misal_half_miss", cache_line_miss, 1'b1);
    check("misal_half_cnt", cache_line_misscnt, 8'd1);
    dwrite(32'h8000_0000, 32'h1234_5678, 2'd3);
    check("dword_miss", cache_line_miss, 1'b1);
    check("dword_cnt", cache_line_misscnt, 8'd2);
    dread(32'h8000_0000);
    check("misal_untouched", dcache_line_out, 32'h0fff_0000);
    check("hit_clears_miss", cache_line_miss, 1'b0);

    // Dual-port read in one cycle.
    dcache_line_rdaddr = 32'h8000_0010;
    icache_line_rdaddr = 32'h8000_0014;
    dcache_line_rdreq  = 1'b1;
    icache_line_rdreq  = 1'b1;
    tick();
    dcache_line_rdreq  = 1'b0;
    icache_line_rdreq  = 1'b0;
    check("dual_valids", {dcache_line_out_valid, icache_line_out_valid}, 2'b11);
    check("dual_d_data", dcache_line_out, 32'h0fff_0004);
    check("dual_i_data", icache_line_out, 32'h0fff_0005);

    // Dirty words 1 and 3, then flush+fill with new_tag latched at the pulse.
    dwrite(32'h8000_000c, 32'h3333_3333, 2'd2);
    clear_monitor(32'h1234_5600);
    pulse(1'b1, 1'b1, 32'h1234_5678);
    check("flush_ready_low", cache_line_ready, 1'b0);
    wait_ready(2000);
    check("flush_wr_count", wr_q.size(), EXP_WRS);
    check("flush_wr_addr1", wr_q[W1], 32'h8000_0004);
    check("flush_wr_addr3", wr_q[W3], 32'h8000_000c);
    check("flush_wr_data1", wr_data_q[W1], 32'hdead_11ef);
    check("flush_wr_data3", wr_data_q[W3], 32'h3333_3333);
    check("flush_before_fill", wr_after_rd, 0);
    check("flush_fill_first", first_rd, 32'h1234_5600);
    check("flush_fill_count", rd_count, 32);
    check("flush_fill_seq", rd_addr_err, 0);
    check("flush_dirty_clear", cache_line_dirty, 1'b0);
    check("flush_misscnt_clear", cache_line_misscnt, 8'd0);

    // New region data, then same-cycle write/read returns pre-write data.
    dread(32'h1234_5608);
    check("newreg_data", dcache_line_out, 32'h0fff_1582);
    dcache_line_wraddr = 32'h1234_5608;
    dcache_line_in = 32'hcafe_f00d;
    dcache_line_in_wordlen = 2'd2;
    dcache_line_wrreq = 1'b1;
    dcache_line_rdaddr = 32'h1234_5608;
    dcache_line_rdreq = 1'b1;
    tick();
    dcache_line_wrreq = 1'b0;
    check("raw_old_data", dcache_line_out, 32'h0fff_1582);
    tick();
    dcache_line_rdreq = 1'b0;
    check("raw_new_data", dcache_line_out, 32'hcafe_f00d);

    // Old region now misses, out bus holds.
    dread(32'h8000_0008);
    check("old_reg_valid", dcache_line_out_valid, 1'b0);
    check("old_reg_hold", dcache_line_out, 32'hcafe_f00d);
    check("old_reg_miss", cache_line_miss, 1'b1);
    check("old_reg_cnt", cache_line_misscnt, 8'd1);

    // Miss counter saturation.
    icache_line_rdaddr = 32'h4000_0010;
    icache_line_rdreq = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cache_line_miss !== 1'b1) nomiss++;
    end
    icache_line_rdreq = 1'b0;
    check("sat_miss_every_cycle", nomiss, 0);
    check("sat_misscnt", cache_line_misscnt, 8'd255);
    check("sat_i_valid", icache_line_out_valid, 1'b0);

    // Fill without flush discards dirty data and clears the counter.
    clear_monitor(32'h8000_0000);
    pulse(1'b1, 1'b0, 32'h8000_0000);
    wait_ready(1000);
    check("refill_misscnt", cache_line_misscnt, 8'd0);
    check("refill_no_wr", wr_q.size(), 0);
    check("refill_dirty", cache_line_dirty, 1'b0);

    // Flush of a clean line stays idle.
    pulse(1'b0, 1'b1, 32'h0);
    check("clean_flush_ready", cache_line_ready, 1'b1);
    repeat (3) tick();
    check("clean_flush_no_wr", wr_q.size(), 0);

    // Pause mid-fill, busy-time request, then reset mid-fill.
    clear_monitor(32'h4000_0000);
    pulse(1'b1, 1'b0, 32'h4000_0000);
    repeat (20) tick();
    cache_line_pause = 1'b1;
    tick();
    watched_strobes = 0;
    watch_strobes = 1;
    dread(32'h8000_0008);
    check("busy_rd_valid", dcache_line_out_valid, 1'b0);
    check("busy_rd_miss", cache_line_miss, 1'b1);
    repeat (9) tick();
    watch_strobes = 0;
    check("pause_no_strobes", watched_strobes, 0);
    check("busy_misscnt_frozen", cache_line_misscnt, 8'd0);
    check("pause_ready_low", cache_line_ready, 1'b0);
    cache_line_pause = 1'b0;
    repeat (15) tick();
    check("midfill_busy", cache_line_ready, 1'b0);
    check("pause_fill_seq", rd_addr_err, 0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("rst2_ready", cache_line_ready, 1'b1);
    check("rst2_strobes", {mem_wrreq, mem_rdreq}, 2'b00);
    watched_strobes = 0;
    watch_strobes = 1;
    repeat (20) tick();
    watch_strobes = 0;
    check("rst2_no_strobes", watched_strobes, 0);
    dread(32'h8000_0008);
    check("rst2_old_valid", dcache_line_out_valid, 1'b0);
    check("rst2_old_miss", cache_line_miss, 1'b1);
    check("no_rd_wr_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
